vec_add_acc: RTL and testbench
==============================

Name: vec_add_acc

Overview:
- Parametrised, pipelined successor to the team's 8-bit combinational adder: LANES independent unsigned adders of WIDTH bits, each widened by GUARD bits.
- Two modes: elementwise (one result per input beat) or accumulate (per-lane running sum of a+b over a packet, one result on the last beat).
- Sits between tensor-buffer readers and the writeback path; both sides use valid/ready streams.

Parameters:
- WIDTH, 8, bits per input lane element.
- LANES, 4, number of parallel lanes.
- GUARD, 8, extra result bits per lane (OUT_W = WIDTH+GUARD); must be >= 1.
- CNT_W, 16, width of the beat counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- in_a  input  LANES*WIDTH  operand a; lane i at bits [i*WIDTH +: WIDTH].
- in_b  input  LANES*WIDTH  operand b; same packing.
- in_last  input  1  last beat of packet.
- mode  input  1  0 = elementwise, 1 = accumulate; sampled on the first beat of a packet.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_sum  output  LANES*OUT_W  per-lane result; lane i at [i*OUT_W +: OUT_W].
- out_ovf  output  LANES  per-lane overflow flag.
- out_beats  output  CNT_W  beats summed into this result; saturates at all-ones.

Behaviour:
- Beat accepted when in_valid && in_ready. Result taken when out_valid && out_ready.
- in_ready = !out_valid || out_ready (combinational; one output register).
- Reset values: out_valid=0, out_sum=0, out_ovf=0, out_beats=0. Accumulators and counter cleared; FSM to IDLE.
- Lane arithmetic: a and b zero-extended to OUT_W. Per-lane sum = acc + a + b. Wraps modulo 2^OUT_W unless SATURATE_EN is defined.
- FSM states: IDLE, ACC.
- IDLE, accepted beat:
  - mode latched.
  - If mode=0, or in_last=1: output register loads a+b per lane next edge, out_beats=1, out_ovf=0; stay IDLE.
  - Else (mode=1, in_last=0): acc=a+b, count=1, go ACC.
- ACC, accepted beat:
  - mode input ignored.
  - acc += a+b; count increments, saturating at 2^CNT_W-1.
  - Per-lane ovf set sticky if the carry-out beyond OUT_W occurs.
  - If in_last: output register loads new acc, count and ovf; acc, count and ovf cleared; go IDLE.
- Latency: result valid on the cycle after the accepting edge of the producing beat (1 cycle).
- Non-last accumulate beats produce no output.
- Output register holds stable while out_valid && !out_ready.
- Simultaneous take-and-load: a result taken in the same cycle a new beat completes is replaced without a bubble.
- Reset mid-packet discards the partial accumulation; the next accepted beat starts a new packet.

Optional Feature:
- Macro: VEC_ADD_ACC_SATURATE_EN.
- Defined: any lane sum exceeding 2^OUT_W-1 clamps to 2^OUT_W-1 and holds there for the rest of the packet; out_ovf is still set.
- Undefined: results wrap modulo 2^OUT_W; out_ovf marks the wrap.

Test Plan (WIDTH=8, LANES=4, GUARD=8, OUT_W=16):
1. Assert rst 2 cycles with in_valid=1 -> out_valid=0, out_sum=0, out_ovf=0, out_beats=0; no beat accepted.
2. mode=0, a={255,1,0,128}, b={255,2,0,128}, out_ready=1 -> next cycle out_valid=1, out_sum={510,3,0,256}, out_ovf=0, out_beats=1.
3. mode=0, out_ready=0, two back-to-back beats -> first result held stable, in_ready=0 after first accept. Raise out_ready -> second beat accepted and its result appears one cycle later.
4. mode=1, 3 beats of a=b=100 all lanes, in_last on beat 3 -> exactly one result: out_sum=600 per lane, out_beats=3, out_ovf=0.
5. mode=1, 129 beats of a=b=255, last on beat 129 -> out_beats=129 and out_ovf=1 in both builds. Wrap build: out_sum=254 per lane. VEC_ADD_ACC_SATURATE_EN build: out_sum=65535 per lane.
6. mode=1, 2 beats of a=b=5, then rst for 1 cycle, then one beat mode=1, a=b=1, in_last=1 -> out_sum=2, out_beats=1.

Source files
------------

// File: rtl/vec_add_acc.sv
// ---------------------------------------------------------------------------
// vec_add_acc
//   LANES independent unsigned adders of WIDTH bits. Each result is widened
//   by GUARD bits (OUT_W = WIDTH + GUARD, GUARD >= 1). Two modes are chosen
//   on the first beat of a packet:
//     mode = 0 : elementwise. Each accepted beat gives one result, a + b
//                per lane.
//     mode = 1 : accumulate. A running per-lane sum of a + b is kept over
//                the packet. One result is produced on the in_last beat.
//   The block has one output register, so the result appears one cycle
//   after the beat that produces it is accepted.
//
//   Optional feature (macro VEC_ADD_ACC_SATURATE_EN):
//     defined   - a lane accumulator that goes past 2^OUT_W-1 clamps to
//                 all-ones and stays there for the rest of the packet.
//     undefined - lane accumulators wrap modulo 2^OUT_W.
//   In both builds out_ovf reports the overflow.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   input beat valid
//   in_ready   block can accept a beat (= !out_valid || out_ready)
//   in_a/in_b  operands; lane i at [i*WIDTH +: WIDTH]
//   in_last    last beat of the packet
//   mode       0 = elementwise, 1 = accumulate; sampled on the first beat
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_sum    per-lane result; lane i at [i*OUT_W +: OUT_W]
//   out_ovf    per-lane overflow flag
//   out_beats  number of beats summed into the result (saturating)
// ---------------------------------------------------------------------------
module vec_add_acc #(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int GUARD = 8,
    parameter int CNT_W = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [LANES*WIDTH-1:0]          in_a,
    input  logic [LANES*WIDTH-1:0]          in_b,
    input  logic                            in_last,
    input  logic                            mode,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [LANES*(WIDTH+GUARD)-1:0]  out_sum,
    output logic [LANES-1:0]                out_ovf,
    output logic [CNT_W-1:0]                out_beats
);

    localparam int OUT_W = WIDTH + GUARD;
    localparam int SUM_W = OUT_W + 1;   // one extra bit catches the carry-out

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [LANES*OUT_W-1:0]   acc_q, acc_d;
    logic [LANES-1:0]         ovf_acc_q, ovf_acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     out_valid_q, out_valid_d;
    logic [LANES*OUT_W-1:0]   out_sum_q, out_sum_d;
    logic [LANES-1:0]         out_ovf_q, out_ovf_d;
    logic [CNT_W-1:0]         out_beats_q, out_beats_d;

    logic                     beat;
    logic [LANES*OUT_W-1:0]   pair_sum;    // a + b per lane (this cannot overflow)
    logic [LANES*OUT_W-1:0]   acc_add;     // acc + a + b per lane, wrapped or clamped
    logic [LANES-1:0]         lane_carry;  // carry-out beyond OUT_W this beat
    logic [CNT_W-1:0]         cnt_inc;

    assign in_ready = !out_valid_q || out_ready;
    assign beat     = in_valid && in_ready;
    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [SUM_W-1:0] full_sum;

            assign pair_sum[gi*OUT_W +: OUT_W] = OUT_W'(in_a[gi*WIDTH +: WIDTH])
                                               + OUT_W'(in_b[gi*WIDTH +: WIDTH]);
            assign full_sum = SUM_W'(acc_q[gi*OUT_W +: OUT_W])
                            + SUM_W'(in_a[gi*WIDTH +: WIDTH])
                            + SUM_W'(in_b[gi*WIDTH +: WIDTH]);
            assign lane_carry[gi] = full_sum[OUT_W];
`ifdef VEC_ADD_ACC_SATURATE_EN
            // Once a lane has overflowed in this packet it stays pinned at
            // all-ones, even on later beats that add zero.
            assign acc_add[gi*OUT_W +: OUT_W] = (full_sum[OUT_W] || ovf_acc_q[gi])
                                              ? {OUT_W{1'b1}} : full_sum[OUT_W-1:0];
`else
            assign acc_add[gi*OUT_W +: OUT_W] = full_sum[OUT_W-1:0];
`endif
        end
    endgenerate

    // State register and every datapath flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            ovf_acc_q   <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= '0;
            out_beats_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ovf_acc_q   <= ovf_acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
            out_beats_q <= out_beats_d;
        end
    end

    // Next-state logic. Only a mode=1 beat that is not the last one opens an
    // accumulate packet, so being in ST_ACC stands in for the latched mode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (beat && mode && !in_last) state_d = ST_ACC;
            ST_ACC:  if (beat && in_last)          state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath logic.
    always_comb begin
        acc_d       = acc_q;
        ovf_acc_d   = ovf_acc_q;
        cnt_d       = cnt_q;
        // A result that is being taken drops out. A result that is not taken
        // is held. A beat that produces a result below overrides both, which
        // gives take-and-load with no bubble.
        out_valid_d = out_valid_q && !out_ready;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;
        out_beats_d = out_beats_q;
        if (beat) begin
            case (state_q)
                ST_IDLE: begin
                    if (!mode || in_last) begin
                        out_valid_d = 1'b1;
                        out_sum_d   = pair_sum;
                        out_ovf_d   = '0;
                        out_beats_d = CNT_W'(1);
                    end else begin
                        acc_d     = pair_sum;
                        ovf_acc_d = '0;
                        cnt_d     = CNT_W'(1);
                    end
                end
                ST_ACC: begin
                    if (in_last) begin
                        out_valid_d = 1'b1;
                        out_sum_d   = acc_add;
                        out_ovf_d   = ovf_acc_q | lane_carry;
                        out_beats_d = cnt_inc;
                        acc_d       = '0;
                        ovf_acc_d   = '0;
                        cnt_d       = '0;
                    end else begin
                        acc_d     = acc_add;
                        ovf_acc_d = ovf_acc_q | lane_carry;
                        cnt_d     = cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;
    assign out_beats = out_beats_q;

endmodule

// File: tb/tb_vec_add_acc.sv
// ---------------------------------------------------------------------------
// tb_vec_add_acc
//   Self-checking bench for vec_add_acc using the default parameters.
//   A behavioural model turns each packet into its expected result with
//   plain integer arithmetic. Results the DUT hands downstream are collected
//   into a queue and compared against the model's queue.
//   Define VEC_ADD_ACC_SATURATE_EN for both the bench and the RTL to check
//   the clamping build.
// ---------------------------------------------------------------------------
module tb_vec_add_acc;

    localparam int WIDTH = 8;
    localparam int LANES = 4;
    localparam int GUARD = 8;
    localparam int CNT_W = 16;
    localparam int OUT_W = WIDTH + GUARD;

    typedef logic [LANES*WIDTH-1:0] vec_t;
    typedef struct packed {
        logic [LANES*OUT_W-1:0] sum;
        logic [LANES-1:0]       ovf;
        logic [CNT_W-1:0]       beats;
    } res_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    vec_t                   in_a = '0;
    vec_t                   in_b = '0;
    logic                   in_last = 1'b0;
    logic                   mode = 1'b0;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic [LANES*OUT_W-1:0] out_sum;
    logic [LANES-1:0]       out_ovf;
    logic [CNT_W-1:0]       out_beats;

    int   checks = 0;
    int   failures = 0;
    res_t exp_q[$];
    res_t obs_q[$];

    vec_add_acc #(.WIDTH(WIDTH), .LANES(LANES), .GUARD(GUARD), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_ovf(out_ovf), .out_beats(out_beats)
    );

    always #5 clk = ~clk;

    // Record every result that is taken at the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready)
            obs_q.push_back({out_sum, out_ovf, out_beats});
    end

    // Reference model for one packet: per-lane total of a+b over all beats.
    function automatic res_t model(input vec_t pa[$], input vec_t pb[$]);
        res_t   r;
        longint maxv = (longint'(1) << OUT_W) - 1;
        longint maxc = (longint'(1) << CNT_W) - 1;
        longint tot;
        r = '0;
        r.beats = (longint'(pa.size()) > maxc) ? CNT_W'(maxc) : CNT_W'(pa.size());
        for (int l = 0; l < LANES; l++) begin
            tot = 0;
            for (int k = 0; k < pa.size(); k++)
                tot += longint'(pa[k][l*WIDTH +: WIDTH]) + longint'(pb[k][l*WIDTH +: WIDTH]);
            r.ovf[l] = (tot > maxv);
`ifdef VEC_ADD_ACC_SATURATE_EN
            r.sum[l*OUT_W +: OUT_W] = (tot > maxv) ? OUT_W'(maxv) : OUT_W'(tot);
`else
            r.sum[l*OUT_W +: OUT_W] = OUT_W'(tot);
`endif
        end
        return r;
    endfunction

    function automatic vec_t splat(input int v);
        vec_t x;
        for (int l = 0; l < LANES; l++) x[l*WIDTH +: WIDTH] = WIDTH'(v);
        return x;
    endfunction

    // Present one beat and hold it until it is accepted (bounded wait).
    task automatic send_beat(input vec_t a, input vec_t b, input logic last, input logic md);
        in_a = a; in_b = b; in_last = last; mode = md; in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Send a packet and queue the result(s) the model expects.
    // fixed < 0 gives random operands; otherwise every lane uses a=b=fixed.
    task automatic run_packet(input bit md, input int n, input int fixed);
        vec_t pa[$], pb[$], sa[$], sb[$];
        vec_t a, b;
        for (int k = 0; k < n; k++) begin
            if (fixed < 0) begin
                a = vec_t'($urandom); b = vec_t'($urandom);
            end else begin
                a = splat(fixed); b = splat(fixed);
            end
            if (!md) begin
                send_beat(a, b, 1'($urandom_range(0, 1)), 1'b0);
                sa = '{a}; sb = '{b};
                exp_q.push_back(model(sa, sb));
            end else begin
                // Mode is only sampled on the first beat; later beats get noise.
                send_beat(a, b, k == n - 1, (k == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
                pa.push_back(a); pb.push_back(b);
            end
        end
        if (md) exp_q.push_back(model(pa, pb));
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (obs_q.size() >= exp_q.size() && !out_valid) break;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_a = splat(7); in_b = splat(9); mode = 1'b0; in_last = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0 || out_sum !== '0 || out_ovf !== '0 || out_beats !== '0) begin
                failures++;
                $display("FAIL reset_state cyc=%0d got valid=%b sum=%h ovf=%b beats=%0d expected all zero",
                         c, out_valid, out_sum, out_ovf, out_beats);
            end
        end
        in_valid = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_accept got out_valid=%b expected 0", out_valid);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_elementwise();
        vec_t a = {8'd255, 8'd1, 8'd0, 8'd128};
        vec_t b = {8'd255, 8'd2, 8'd0, 8'd128};
        logic [LANES*OUT_W-1:0] want = {16'd510, 16'd3, 16'd0, 16'd256};
        out_ready = 1'b1;
        send_beat(a, b, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== want || out_ovf !== '0 || out_beats !== 16'd1) begin
            failures++;
            $display("FAIL elem_directed got valid=%b sum=%h ovf=%b beats=%0d expected valid=1 sum=%h ovf=0 beats=1",
                     out_valid, out_sum, out_ovf, out_beats, want);
        end
        exp_q.push_back({want, 4'b0, 16'd1});
        for (int i = 0; i < 12; i++) run_packet(1'b0, 1, -1);
        wait_drain();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL elem_count got %0d results expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL elem_result[%0d] got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure();
        vec_t a1 = vec_t'($urandom), b1 = vec_t'($urandom);
        vec_t a2 = vec_t'($urandom), b2 = vec_t'($urandom);
        vec_t qa[$], qb[$];
        res_t e1, e2;
        qa = '{a1}; qb = '{b1}; e1 = model(qa, qb);
        qa = '{a2}; qb = '{b2}; e2 = model(qa, qb);
        out_ready = 1'b0;
        in_a = a1; in_b = b1; in_last = 1'b1; mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_a = a2; in_b = b2;
        checks++;
        if (out_valid !== 1'b1 || out_sum !== e1.sum || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_first got valid=%b sum=%h in_ready=%b expected valid=1 sum=%h in_ready=0",
                     out_valid, out_sum, in_ready, e1.sum);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_sum !== e1.sum || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got valid=%b sum=%h in_ready=%b expected valid=1 sum=%h in_ready=0",
                         c, out_valid, out_sum, in_ready, e1.sum);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_ready got in_ready=%b expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_sum !== e2.sum || out_beats !== 16'd1) begin
            failures++;
            $display("FAIL bp_second got valid=%b sum=%h beats=%0d expected valid=1 sum=%h beats=1",
                     out_valid, out_sum, out_beats, e2.sum);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain got out_valid=%b expected 0", out_valid);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_accumulate();
        out_ready = 1'b1;
        run_packet(1'b1, 3, 100);
        wait_drain();
        checks++;
        if (obs_q.size() != 1 || obs_q[0].sum !== {LANES{16'd600}} || obs_q[0].beats !== 16'd3
            || obs_q[0].ovf !== '0) begin
            failures++;
            $display("FAIL acc_directed got n=%0d result=%h expected one result sum=600/lane beats=3 ovf=0",
                     obs_q.size(), obs_q[0]);
        end
        obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 8; i++) run_packet(1'b1, $urandom_range(1, 6), -1);
        wait_drain();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL acc_count got %0d results expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL acc_result[%0d] got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_long_packet();
`ifdef VEC_ADD_ACC_SATURATE_EN
        logic [OUT_W-1:0] lane_want = 16'd65535;
`else
        logic [OUT_W-1:0] lane_want = 16'd254;
`endif
        out_ready = 1'b1;
        run_packet(1'b1, 129, 255);
        wait_drain();
        checks++;
        if (obs_q.size() != 1 || obs_q[0].sum !== {LANES{lane_want}} || obs_q[0].beats !== 16'd129
            || obs_q[0].ovf !== {LANES{1'b1}}) begin
            failures++;
            $display("FAIL long_packet got n=%0d result=%h expected sum=%0d/lane beats=129 ovf=1111",
                     obs_q.size(), obs_q[0], lane_want);
        end
        checks++;
        if (obs_q[0] !== exp_q[0]) begin
            failures++;
            $display("FAIL long_model got %h expected %h", obs_q[0], exp_q[0]);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid_packet();
        out_ready = 1'b1;
        send_beat(splat(5), splat(5), 1'b0, 1'b1);
        send_beat(splat(5), splat(5), 1'b0, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        send_beat(splat(1), splat(1), 1'b1, 1'b1);
        wait_drain();
        checks++;
        if (obs_q.size() != 1 || obs_q[0].sum !== {LANES{16'd2}} || obs_q[0].beats !== 16'd1
            || obs_q[0].ovf !== '0) begin
            failures++;
            $display("FAIL reset_mid got n=%0d result=%h expected sum=2/lane beats=1 ovf=0",
                     obs_q.size(), obs_q[0]);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        bit done = 1'b0;
        fork
            begin
                for (int p = 0; p < 30; p++)
                    run_packet(1'($urandom_range(0, 1)), $urandom_range(1, 5), -1);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL b2b_count got %0d results expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL b2b_result[%0d] got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_elementwise();
        test_backpressure();
        test_accumulate();
        test_long_packet();
        test_reset_mid_packet();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
